rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/arb_pkg.sv | 45 ++++
 rtl/fixed_prio4.sv | 18 +
 rtl/rr_arbiter4.sv | 111 +++++++++++
 tb/tb_rr_arbiter4.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// The rotate helpers map the request vector into and out of the fixed-priority frame.
package arb_pkg;

  localparam int N_REQ   = 4;
  localparam int TIMER_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef logic [1:0]         ptr_t;
  typedef logic [TIMER_W-1:0] timer_t;

  // r[i] = v[(i + s) mod N_REQ]
  function automatic logic [N_REQ-1:0] rot_right(input logic [N_REQ-1:0] v, input ptr_t s);
    logic [N_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      r[i] = v[(i + int'(s)) % N_REQ];
    end
    return r;
  endfunction

  // Inverse of rot_right: r[(i + s) mod N_REQ] = v[i]
  function automatic logic [N_REQ-1:0] rot_left(input logic [N_REQ-1:0] v, input ptr_t s);
    logic [N_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      r[(i + int'(s)) % N_REQ] = v[i];
    end
    return r;
  endfunction

  function automatic ptr_t onehot_to_idx(input logic [N_REQ-1:0] oh);
    ptr_t r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) r = ptr_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_prio4.sv
// Combinational 4-bit fixed-priority encoder, bit 3 highest; one-hot out, zero if no request.
// Zero latency, no flow control.
module fixed_prio4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] sel
);

  always_comb begin
    sel = '0;
    if (req[3])      sel = 4'b1000;
    else if (req[2]) sel = 4'b0100;
    else if (req[1]) sel = 4'b0010;
    else if (req[0]) sel = 4'b0001;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// 4-way round-robin arbiter with held grants: req->grant 1 cycle, grant held until done/req drop.
// Optional forced release after TIMEOUT busy cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             timeout
);

  state_t           state, state_nxt;
  ptr_t             ptr, ptr_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [N_REQ-1:0] req_rot, sel_rot, sel;
  ptr_t             rot_amt;
  logic             rel_normal;

`ifdef ARB_TIMEOUT_EN
  localparam timer_t TIMER_LAST = timer_t'(TIMEOUT - 1);
  timer_t timer, timer_nxt;
  logic   timeout_nxt;
`endif

  // Rotating by ptr+1 puts requester ptr on bit 3, so descending search starts there.
  assign rot_amt = ptr_t'(ptr + 2'd1);
  assign req_rot = rot_right(req, rot_amt);

  fixed_prio4 u_prio (
    .req (req_rot),
    .sel (sel_rot)
  );

  assign sel        = rot_left(sel_rot, rot_amt);
  assign rel_normal = done | ~|(req & grant);
  assign busy       = (state == BUSY);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
`ifdef ARB_TIMEOUT_EN
    timer_nxt   = timer;
    timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt = sel;
          state_nxt = BUSY;
          ptr_nxt   = ptr_t'(onehot_to_idx(sel) - 2'd1);
`ifdef ARB_TIMEOUT_EN
          timer_nxt = '0;
`endif
        end
      end
      BUSY: begin
        if (rel_normal) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (timer == TIMER_LAST) begin
          grant_nxt   = '0;
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
`endif
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= 2'd3;
`ifdef ARB_TIMEOUT_EN
      timer   <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
`ifdef ARB_TIMEOUT_EN
      timer   <= timer_nxt;
      timeout <= timeout_nxt;
`endif
    end
  end

`ifndef ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  a_timeout_range: assert property (@(posedge clk) (TIMEOUT >= 2) && (TIMEOUT <= 255));
  a_grant_onehot:  assert property (@(posedge clk) disable iff (reset) $onehot0(grant));

endmodule

// File: tb/tb_rr_arbiter4.sv
// Randomized bench for rr_arbiter4 with a round-robin reference model and directed scenarios.
// The model works from requester indices and a priority pointer as plain integers.
module tb_rr_arbiter4;

`ifdef ARB_TIMEOUT_EN
  localparam bit TE = 1'b1;
  localparam int TO = 4;
`else
  localparam bit TE = 1'b0;
  localparam int TO = 16;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int n_pass = 0;
  int n_tot  = 0;

  rr_arbiter4 #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: state updated on each rising edge from sampled inputs.
  bit model_live = 1'b0;
  bit m_busy = 1'b0;
  int m_k = 0;
  int m_ptr = 3;
  int m_timer = 0;
  bit m_to = 1'b0;
  int wait_cnt[4] = '{0, 0, 0, 0};
  int max_wait = 0;

  always @(posedge clk) begin
    model_live = 1'b1;
    if (reset) begin
      m_busy = 1'b0; m_ptr = 3; m_timer = 0; m_to = 1'b0;
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    end else begin
      m_to = 1'b0;
      if (!m_busy) begin
        if (req != 4'b0) begin
          int k;
          bit found;
          k = 0; found = 1'b0;
          for (int j = 0; j < 4; j++) begin
            int c;
            c = (m_ptr - j + 4) % 4;
            if (!found && req[c]) begin k = c; found = 1'b1; end
          end
          m_busy = 1'b1; m_k = k; m_ptr = (k + 3) % 4; m_timer = 0;
          for (int i = 0; i < 4; i++) begin
            if (i == k || !req[i]) wait_cnt[i] = 0;
            else begin
              wait_cnt[i]++;
              if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
          end
        end
      end else if (done || !req[m_k]) begin
        m_busy = 1'b0;
      end else if (TE && m_timer == TO - 1) begin
        m_busy = 1'b0; m_to = 1'b1;
      end else begin
        m_timer++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("grant", int'(grant), m_busy ? (1 << m_k) : 0);
      chk("busy", int'(busy), int'(m_busy));
      chk("timeout", int'(timeout), int'(m_to));
      chk("onehot0", int'($onehot0(grant)), 1);
    end
  end

  task automatic do_reset();
    reset = 1'b1; req = 4'b0; done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int seq[9] = '{8, 0, 4, 0, 2, 0, 1, 0, 8};

  initial begin
    reset = 1'b1; req = 4'b0; done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ptr", int'(dut.ptr), 3);

    // First grant right after reset, pointer moves below the winner
    reset = 1'b0; req = 4'b0101;
    @(negedge clk);
    chk("t29_grant", int'(grant), 4);
    chk("t29_busy", int'(busy), 1);
    chk("t29_ptr", int'(dut.ptr), 1);
    chk("t29_model_ptr", m_ptr, 1);

    // All requesting, done one cycle after each grant
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("t30_seq%0d", i), int'(grant), seq[i]);
      done = (seq[i] != 0);
    end
    done = 1'b0;

    // Grant held across unrelated req changes, released when own req drops
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    chk("t31_grant", int'(grant), 2);
    req = 4'b1011;
    @(negedge clk);
    chk("t31_hold1", int'(grant), 2);
    @(negedge clk);
    chk("t31_hold2", int'(grant), 2);
    req = 4'b1001;
    @(negedge clk);
    chk("t31_drop", int'(grant), 0);

    // Reset while busy
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    chk("t32_grant", int'(grant), 4);
    reset = 1'b1;
    @(negedge clk);
    chk("t32_rst_grant", int'(grant), 0);
    chk("t32_rst_busy", int'(busy), 0);
    chk("t32_rst_ptr", int'(dut.ptr), 3);
    chk("t32_rst_to", int'(timeout), 0);
    reset = 1'b0; req = 4'b0100;
    @(negedge clk);
    chk("t32_regrant", int'(grant), 4);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t33_held", int'(grant), 1);
    end
    @(negedge clk);
    chk("t33_rel", int'(grant), 0);
    chk("t33_to", int'(timeout), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t33_held2", int'(grant), 1);
      chk("t33_to_low", int'(timeout), 0);
      if (i == 3) done = 1'b1;
    end
    @(negedge clk);
    chk("t33_done_rel", int'(grant), 0);
    chk("t33_done_to", int'(timeout), 0);
    done = 1'b0;
`endif

    // Random traffic
    do_reset();
    max_wait = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done  = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("starvation_bound", int'(max_wait <= 3), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
